// File: rtl/mult_pkg.sv
// Shared definitions for the sequential multiplier family: control states,
// iteration count and the operand geometry the fixed 8-bit adder supports.
package mult_pkg;

    localparam int MULT_WIDTH = 8;
    localparam int MULT_CNT_W = 3;
    localparam int MULT_ITERS = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/brent_kung_8.sv
// 8-bit Brent-Kung parallel-prefix adder: log-depth up-sweep of group
// generate/propagate followed by a sparse down-sweep for the odd positions.
module brent_kung_8 (
    output logic [7:0] sum,
    output logic       cout,
    input  logic [7:0] in1,
    input  logic [7:0] in2,
    input  logic       cin
);

    logic [7:0] g;
    logic [7:0] p;
    logic [7:0] c;

    // Group terms named g<hi><lo> / p<hi><lo>; cin is folded into bit 0 so
    // every prefix that reaches bit 0 needs only its generate term.
    logic g0c;
    logic g10, g32, g54, g76;
    logic p32, p54, p76;
    logic g30, g74, p74;
    logic g70;
    logic g50, g20, g40, g60;

    assign g = in1 & in2;
    assign p = in1 ^ in2;

    assign g0c = g[0] | (p[0] & cin);

    assign g10 = g[1] | (p[1] & g0c);
    assign g32 = g[3] | (p[3] & g[2]);
    assign p32 = p[3] & p[2];
    assign g54 = g[5] | (p[5] & g[4]);
    assign p54 = p[5] & p[4];
    assign g76 = g[7] | (p[7] & g[6]);
    assign p76 = p[7] & p[6];

    assign g30 = g32 | (p32 & g10);
    assign g74 = g76 | (p76 & g54);
    assign p74 = p76 & p54;

    assign g70 = g74 | (p74 & g30);

    assign g50 = g54 | (p54 & g30);
    assign g20 = g[2] | (p[2] & g10);
    assign g40 = g[4] | (p[4] & g30);
    assign g60 = g[6] | (p[6] & g50);

    assign c    = {g60, g50, g40, g30, g20, g10, g0c, cin};
    assign sum  = p ^ c;
    assign cout = g70;

endmodule

// File: rtl/seq_shift_add_mult_8.sv
// Radix-2 shift-and-add 8x8 unsigned multiplier: one partial product per
// cycle through a shared 8-bit prefix adder, 9 busy cycles per product.
module seq_shift_add_mult_8
    import mult_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     in1,
    input  logic [WIDTH-1:0]     in2,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    generate
        if (WIDTH != MULT_WIDTH || CNT_W != MULT_CNT_W) begin : g_bad_width
            $error("seq_shift_add_mult_8 supports only WIDTH=8 / CNT_W=3");
        end
    endgenerate

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic [WIDTH-1:0]     add_b;
    logic [WIDTH-1:0]     add_sum;
    logic                 add_cout;
    logic [2*WIDTH-1:0]   shifted;
    logic                 last_iter;

    assign add_b = q_q[0] ? mcand_q : '0;

    brent_kung_8 u_add (
        .sum  (add_sum),
        .cout (add_cout),
        .in1  (acc_q),
        .in2  (add_b),
        .cin  (1'b0)
    );

    // The adder's carry-out becomes the accumulator MSB as {acc,q} shifts right.
    assign shifted   = {add_cout, add_sum, q_q[WIDTH-1:1]};
    assign last_iter = (cnt_q == CNT_W'(MULT_ITERS - 1));

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (rst) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            acc_q     <= '0;
            q_q       <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    always_comb begin
        // NOTE: default first, so no path through the case can infer a latch.
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_iter) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        q_d       = q_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d = in1;
                    q_d     = in2;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                {acc_d, q_d} = shifted;
                cnt_d        = cnt_q + CNT_W'(1);
                // Load the result on the final shift so it is already valid
                // during the DONE cycle and held from then on.
                if (last_iter) product_d = shifted;
            end
            default: ;
        endcase
    end

    always_comb begin
        busy    = (state_q != IDLE);
        done    = (state_q == DONE);
        product = product_q;
    end

endmodule

// File: tb/tb_seq_shift_add_mult_8.sv
// Directed and randomised checks of the sequential 8x8 multiplier: latency,
// busy window, done pulse, start filtering and synchronous reset abort.
module tb_seq_shift_add_mult_8;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  in1;
    logic [7:0]  in2;
    logic        busy;
    logic        done;
    logic [15:0] product;

    int errors = 0;
    int checks = 0;

    seq_shift_add_mult_8 dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .in1     (in1),
        .in2     (in2),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Presents operands with start for one edge, then scrambles the inputs.
    task automatic start_op(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        in1   = a;
        in2   = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        in1   = 8'($urandom);
        in2   = 8'($urandom);
    endtask

    // Counts falling edges after the accept edge until done; lat=0 on timeout.
    task automatic wait_done(output int lat, output int busy_cnt);
        lat      = 0;
        busy_cnt = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic run_check(input string tag, input logic [7:0] a, input logic [7:0] b,
                             input logic [15:0] exp, input bit full);
        int lat;
        int bc;
        start_op(a, b);
        wait_done(lat, bc);
        check({tag, " latency"}, lat, 9);
        check({tag, " product"}, product, exp);
        if (full) begin
            check({tag, " busy cycles"}, bc, 9);
            @(negedge clk);
            check({tag, " done pulse width"}, done, 1'b0);
            check({tag, " busy after done"}, busy, 1'b0);
            @(negedge clk);
            check({tag, " product held"}, product, exp);
        end
    endtask

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
    } vec_t;

    vec_t vecs[6] = '{
        '{8'h0D, 8'h0B, 16'h008F},
        '{8'hFF, 8'hFF, 16'hFE01},
        '{8'h00, 8'hA5, 16'h0000},
        '{8'h80, 8'h01, 16'h0080},
        '{8'h01, 8'hFF, 16'h00FF},
        '{8'hFF, 8'h01, 16'h00FF}
    };

    initial begin
        int lat;
        int bc;
        int k;
        int seen;
        logic [7:0] ra;
        logic [7:0] rb;

        rst   = 1'b1;
        start = 1'b0;
        in1   = 8'h00;
        in2   = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset product", product, 16'h0000);
        rst = 1'b0;

        for (int i = 0; i < 6; i++)
            run_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].p, 1'b1);

        // start raised mid-RUN and held through DONE is taken from the next IDLE.
        start_op(8'h12, 8'h34);
        repeat (3) @(negedge clk);
        in1   = 8'h99;
        in2   = 8'h99;
        start = 1'b1;
        lat   = 0;
        for (int i = 4; i <= 20; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
        end
        check("overlap first latency", lat, 9);
        check("overlap first product", product, 16'h03A8);
        k = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) check("overlap idle gap busy", busy, 1'b0);
            if (i == 2) begin
                check("overlap second accepted", busy, 1'b1);
                start = 1'b0;
            end
            if (done) begin
                k = i;
                break;
            end
        end
        check("overlap done spacing", k, 10);
        check("overlap second product", product, 16'h5B71);
        @(negedge clk);

        // Synchronous reset during RUN cycle 4 aborts with no done pulse.
        start_op(8'hFF, 8'hFF);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort busy", busy, 1'b0);
        check("abort done", done, 1'b0);
        check("abort product", product, 16'h0000);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        check("abort no activity", seen, 0);
        run_check("post abort", 8'h03, 8'h05, 16'h000F, 1'b1);

        for (int n = 0; n < 1000; n++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            start_op(ra, rb);
            wait_done(lat, bc);
            check($sformatf("rand%0d latency", n), lat, 9);
            check($sformatf("rand%0d %0h*%0h", n, ra, rb), product, 16'(ra) * 16'(rb));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
